// File: rtl/s832_misr_pkg.sv
// s832 response MISR: shared widths, polynomial, FSM states
// and bit positions of each s832 primary output in resp.
package s832_misr_pkg;

    localparam int              S832_WIDTH = 19;
    localparam logic [18:0]     S832_POLY  = 19'h64001;
    localparam int              S832_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int G288 = 0;
    localparam int G290 = 1;
    localparam int G292 = 2;
    localparam int G296 = 3;
    localparam int G298 = 4;
    localparam int G300 = 5;
    localparam int G302 = 6;
    localparam int G310 = 7;
    localparam int G312 = 8;
    localparam int G315 = 9;
    localparam int G322 = 10;
    localparam int G325 = 11;
    localparam int G327 = 12;
    localparam int G43  = 13;
    localparam int G45  = 14;
    localparam int G47  = 15;
    localparam int G49  = 16;
    localparam int G53  = 17;
    localparam int G55  = 18;

endpackage

// File: rtl/s832_misr_core.sv
// Signature register: load seed, fold one response per step,
// otherwise hold. Also exposes the post-step value for compares.
module s832_misr_core #(
    parameter int               WIDTH = 19,
    parameter logic [WIDTH-1:0] POLY  = 19'h64001
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic [WIDTH-1:0] resp_i,
    output logic [WIDTH-1:0] sig_o,
    output logic [WIDTH-1:0] sig_nxt_o
);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;
    logic [WIDTH-1:0] step_val;

    // shift-left with feedback on the outgoing MSB, then fold resp
    always_comb begin
        step_val = {sig_q[WIDTH-2:0], 1'b0}
                 ^ (sig_q[WIDTH-1] ? POLY : '0)
                 ^ resp_i;
        sig_d = sig_q;
        if (load_i) begin
            sig_d = seed_i;
        end else if (step_i) begin
            sig_d = step_val;
        end
    end

    // signature state, cleared by synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o     = sig_q;
    assign sig_nxt_o = step_val;

endmodule

// File: rtl/s832_resp_misr.sv
// s832 response compactor: run-window FSM, cycle counter, golden
// compare. Define S832_MISR_MASK_EN to add the X-mask input.
module s832_resp_misr #(
    parameter int               WIDTH = s832_misr_pkg::S832_WIDTH,
    parameter logic [WIDTH-1:0] POLY  = s832_misr_pkg::S832_POLY,
    parameter int               CNT_W = s832_misr_pkg::S832_CNT_W
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] num_cycles,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp,
    input  logic [WIDTH-1:0] golden,
`ifdef S832_MISR_MASK_EN
    input  logic [WIDTH-1:0] mask,
`endif
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] cycle_count
);

    import s832_misr_pkg::*;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] num_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [WIDTH-1:0] resp_eff;
    logic [WIDTH-1:0] sig_nxt;
    logic             accept;
    logic             step;
    logic             last;

    assign accept = start && (state_q != RUN);
    assign step   = resp_valid && (state_q == RUN);
    assign last   = (cnt_q == num_q - CNT_W'(1));

`ifdef S832_MISR_MASK_EN
    logic [WIDTH-1:0] mask_q;

    // mask is captured with each accepted start
    always_ff @(posedge CK) begin
        if (RST) begin
            mask_q <= '0;
        end else if (accept) begin
            mask_q <= mask;
        end
    end

    assign resp_eff = resp & ~mask_q;
`else
    assign resp_eff = resp;
`endif

    s832_misr_core #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_core (
        .clk_i     (CK),
        .rst_i     (RST),
        .load_i    (accept),
        .step_i    (step),
        .seed_i    (seed),
        .resp_i    (resp_eff),
        .sig_o     (signature),
        .sig_nxt_o (sig_nxt)
    );

    // control FSM with counter and registered status outputs
    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        cnt_q  <= '0;
                        num_q  <= num_cycles;
                        if (num_cycles == '0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (seed == golden);
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                            pass_q  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (resp_valid) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (sig_nxt == golden);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_s832_resp_misr.sv
// Randomized scoreboard bench for s832_resp_misr: expected results
// are queued at start, a monitor pops them on each rising done.
module tb_s832_resp_misr;

    logic        CK = 1'b0;
    logic        RST;
    logic        start;
    logic [18:0] seed;
    logic [15:0] num_cycles;
    logic        resp_valid;
    logic [18:0] resp;
    logic [18:0] golden;
    logic [18:0] mask;
    logic        busy;
    logic        done;
    logic        pass;
    logic [18:0] signature;
    logic [15:0] cycle_count;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [18:0] sig;
        bit          pass;
        int          cnt;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic done_d = 1'b0;

    s832_resp_misr dut (
        .CK          (CK),
        .RST         (RST),
        .start       (start),
        .seed        (seed),
        .num_cycles  (num_cycles),
        .resp_valid  (resp_valid),
        .resp        (resp),
        .golden      (golden),
`ifdef S832_MISR_MASK_EN
        .mask        (mask),
`endif
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .signature   (signature),
        .cycle_count (cycle_count)
    );

    always #5 CK = ~CK;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", nm, act, req);
        end
    endtask

    // signature as polynomial arithmetic over GF(2):
    // S <- S*x mod P(x) + r, P = x^19+x^18+x^17+x^14+1
    function automatic logic [18:0] model(input logic [18:0] sd,
                                          input logic [18:0] rs[$],
                                          input logic [18:0] mk);
        logic [31:0] s;
        s = {13'd0, sd};
        foreach (rs[i]) begin
            s = s << 1;
            if (s[19]) s = s ^ 32'h000E_4001;
            s = s ^ {13'd0, rs[i] & ~mk};
        end
        return s[18:0];
    endfunction

    // scoreboard monitor: one expected result per rising done
    always @(negedge CK) begin
        if (done === 1'b1 && done_d !== 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done: got done=1, want none");
            end else begin
                mon_e = exp_q.pop_front();
                chk({mon_e.name, "_sig"}, 32'(signature), 32'(mon_e.sig));
                chk({mon_e.name, "_pass"}, 32'(pass), 32'(mon_e.pass));
                chk({mon_e.name, "_cnt"}, 32'(cycle_count),
                    32'(mon_e.cnt));
            end
        end
        done_d = done;
    end

    task automatic cyc_chk(input string nm, input logic [18:0] sd,
                           input bit first);
        @(negedge CK);
        chk({nm, "_busy"}, 32'(busy), 32'd1);
        chk({nm, "_notdone"}, 32'(done), 32'd0);
        if (first) chk({nm, "_seedload"}, 32'(signature), 32'(sd));
        @(posedge CK);
        #1;
    endtask

    task automatic run(input string nm, input logic [18:0] sd,
                       input int n, input logic [18:0] gd_in,
                       input bit gd_match, input logic [18:0] mk,
                       input int gap_pct, input int pat[$],
                       input bit poke);
        logic [18:0] rs[$];
        logic [18:0] fin;
        logic [18:0] gd;
        exp_t        e;
        bit          first;
        int          g;
        int          k;
        for (int i = 0; i < n; i++) rs.push_back(19'($urandom));
        fin = model(sd, rs, mk);
        gd  = gd_match ? fin : gd_in;
        e.sig  = fin;
        e.pass = (fin == gd);
        e.cnt  = n;
        e.name = nm;
        exp_q.push_back(e);
        seed       = sd;
        num_cycles = 16'(n);
        golden     = gd;
        mask       = mk;
        start      = 1'b1;
        @(posedge CK);
        #1;
        start      = 1'b0;
        seed       = 19'($urandom);
        num_cycles = 16'($urandom);
        mask       = 19'($urandom);
        first      = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (pat.size() > i) g = pat[i];
            else g = ($urandom_range(0, 99) < gap_pct) ? 1 : 0;
            if (poke && i == 0 && g == 0) g = 1;
            for (int j = 0; j < g; j++) begin
                resp_valid = 1'b0;
                resp       = 19'($urandom);
                if (poke && i == 0 && j == 0) begin
                    start      = 1'b1;
                    num_cycles = 16'd0;
                end
                cyc_chk(nm, sd, first);
                first = 1'b0;
                start = 1'b0;
            end
            resp_valid = 1'b1;
            resp       = rs[i];
            cyc_chk(nm, sd, first);
            first = 1'b0;
        end
        resp_valid = 1'b0;
        resp       = 19'($urandom);
        k = 0;
        while (done !== 1'b1 && k < 8) begin
            @(posedge CK);
            #1;
            k++;
        end
        if (done !== 1'b1) begin
            checks++;
            fails++;
            $display("FAIL %s_timeout: got done=%b, want 1", nm, done);
        end
        @(negedge CK);
        chk({nm, "_idlebusy"}, 32'(busy), 32'd0);
        #1;
    endtask

    task automatic reset_chk(input string nm);
        @(negedge CK);
        chk({nm, "_sig"}, 32'(signature), 32'd0);
        chk({nm, "_cnt"}, 32'(cycle_count), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_done"}, 32'(done), 32'd0);
        chk({nm, "_pass"}, 32'(pass), 32'd0);
        #1;
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        @(posedge CK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int none[$];
        int gp[$];
        logic [18:0] s;
        gp.push_back(0);
        gp.push_back(1);
        gp.push_back(2);
        RST        = 1'b1;
        start      = 1'b1;
        seed       = 19'h5A5A5;
        num_cycles = 16'd3;
        resp_valid = 1'b1;
        resp       = 19'h12345;
        golden     = '0;
        mask       = '0;
        repeat (3) @(posedge CK);
        #1;
        RST        = 1'b0;
        start      = 1'b0;
        resp_valid = 1'b0;
        reset_chk("reset");

        run("single", 19'h0, 1, 19'h00001, 1'b0, '0, 0, none, 1'b0);
        run("feedback", 19'h40000, 1, 19'h64000, 1'b0, '0, 0, none,
            1'b0);
        run("gapped", 19'($urandom), 3, '0, 1'b1, '0, 0, gp, 1'b0);

        pulse_reset();
        reset_chk("rst2");
        run("zero", 19'h12345, 0, 19'h12345, 1'b0, '0, 0, none, 1'b0);

        seed       = 19'($urandom);
        num_cycles = 16'd5;
        start      = 1'b1;
        @(posedge CK);
        #1;
        start      = 1'b0;
        resp_valid = 1'b1;
        repeat (2) begin
            resp = 19'($urandom);
            @(posedge CK);
            #1;
        end
        RST = 1'b1;
        @(posedge CK);
        #1;
        RST        = 1'b0;
        resp_valid = 1'b0;
        reset_chk("midrun_rst");
        run("after_rst", 19'($urandom), 5, '0, 1'b1, '0, 30, none,
            1'b0);

        run("ign_start", 19'($urandom), 6, '0, 1'b1, '0, 20, none,
            1'b1);
        run("restart", 19'h7FFFF, 4, 19'($urandom), 1'b0, '0, 25,
            none, 1'b0);

        for (int r = 0; r < 12; r++) begin
            s = 19'($urandom);
            run("rand", s, $urandom_range(1, 24), 19'($urandom),
                1'($urandom), '0, 35, none, 1'b0);
        end

`ifdef S832_MISR_MASK_EN
        run("mask_all", 19'h0, 4, 19'h0, 1'b0, 19'h7FFFF, 30, none,
            1'b0);
        run("mask_part", 19'($urandom), 7, '0, 1'b1, 19'($urandom), 30,
            none, 1'b0);
`endif

        repeat (2) @(negedge CK);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
